// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-requester round-robin arbiter driving a shared 4:1 data mux.
// Optional forced rotation after HOLD_MAX grant cycles: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] d,
   output logic [3:0] gnt,
   output logic [1:0] select,
   output logic       busy,
   output logic       q
);

   // state | meaning
   // IDLE  | no owner, gnt = 0, select keeps the last owner
   // GRANT | owner holds a one-hot gnt, select = owner
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] owner;
   logic [1:0] owner_nxt;
   logic [1:0] ptr;
   logic [1:0] ptr_nxt;
   logic [3:0] gnt_nxt;
   logic [1:0] select_nxt;
   logic [3:0] others;
   logic [1:0] win_ptr;
   logic       grant_new;
   logic [1:0] grant_idx;
   logic       hold_expired;

   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("mux_rr_arbiter: HOLD_MAX must be in 2..255");
   end

   // First set bit of r, scanning base, base+1, base+2, base+3 (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
      logic [1:0] idx;
      logic       found;
      rr_pick = base;
      found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = base + 2'(i);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign others  = req & ~(4'b0001 << owner);
   assign win_ptr = rr_pick(req, ptr);

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [7:0] hold_cnt;
   logic [7:0] hold_cnt_nxt;

   assign hold_expired = (hold_cnt == HOLD_LAST);
`else
   assign hold_expired = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      ptr_nxt    = ptr;
      gnt_nxt    = gnt;
      select_nxt = select;
      grant_new  = 1'b0;
      grant_idx  = win_ptr;

      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               grant_new = 1'b1;
            end
         end
         GRANT: begin
            if (req == 4'b0000) begin
               state_nxt = IDLE;
               gnt_nxt   = 4'b0000;
            end else if (!req[owner]) begin
               grant_new = 1'b1;
            end else if (hold_expired && (others != 4'b0000)) begin
               // forced rotation: the owner is skipped even though it still requests
               grant_new = 1'b1;
               grant_idx = rr_pick(others, owner + 2'd1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
         end
      endcase

      if (grant_new) begin
         state_nxt  = GRANT;
         owner_nxt  = grant_idx;
         select_nxt = grant_idx;
         gnt_nxt    = 4'b0001 << grant_idx;
         ptr_nxt    = grant_idx + 2'd1;
      end
   end

`ifdef MUX_ARB_TIMEOUT_EN
   always_comb begin
      hold_cnt_nxt = hold_cnt;
      if (grant_new) begin
         hold_cnt_nxt = 8'd0;
      end else if (state == GRANT && !hold_expired) begin
         hold_cnt_nxt = hold_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= 8'd0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= 2'd0;
         ptr    <= 2'd0;
         gnt    <= 4'b0000;
         select <= 2'd0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         ptr    <= ptr_nxt;
         gnt    <= gnt_nxt;
         select <= select_nxt;
      end
   end

   assign busy = |gnt;
   assign q    = busy ? d[select] : 1'b0;

endmodule
